io_decoder_n: RTL and testbench
===============================

IO_DECODER_N -- requirements
Module: io_decoder_n

Interface
REQ-001 Parameter ADDR_W, default 12: address bus width.
REQ-002 Parameter SEL_BITS, default 2: top address bits selecting a device; N_DEV = 2**SEL_BITS.
REQ-003 Parameter WAIT_W, default 3: width of one wait-state count.
REQ-004 Parameter WAIT_STATES, default {N_DEV{3'd1}}: packed per-device wait count; device k occupies bits [k*WAIT_W +: WAIT_W].
REQ-005 Parameter DEV_MASK, default all ones: bit k set means device k is mapped.
REQ-006 clk  input  1  single clock, rising edge.
REQ-007 nrst  input  1  asynchronous active-low reset.
REQ-008 dbus  input  ADDR_W  address bus.
REQ-009 nwrm  input  1  active-low write; 0 = write, 1 = read.
REQ-010 state_fetch  input  1  CPU fetch state.
REQ-011 state_exec  input  1  CPU execute state.
REQ-012 io_req  input  1  current instruction is an I/O access.
REQ-013 io  output  1  I/O-phase flag; nio  output  1  its complement.
REQ-014 io_rd  output  1  io AND state_exec, combinational.
REQ-015 dev_wr  output  N_DEV  one-hot registered write strobes.
REQ-016 dev_rd  output  N_DEV  one-hot registered read strobes.
REQ-017 dev_addr  output  ADDR_W-SEL_BITS  latched low address bits.
REQ-018 io_wait  output  1  CPU stall request.
REQ-019 io_done  output  1  one-cycle completion pulse.
REQ-020 io_err  output  1  one-cycle unmapped-access pulse, coincident with io_done.

Function
REQ-021 FSM states: IDLE, STROBE, DONE.
REQ-022 Start condition: IDLE AND state_exec AND io_req AND io == 0.
REQ-023 On start: latch idx = dbus[ADDR_W-1 -: SEL_BITS], dir = ~nwrm, dev_addr = dbus low bits, cnt = WAIT_STATES[idx]; set io; go to STROBE.
REQ-024 In STROBE, a mapped idx asserts dev_wr[idx] (dir = 1) or dev_rd[idx] (dir = 0); all other strobe bits remain 0.
REQ-025 In STROBE, cnt decrements each cycle; when cnt == 0 the FSM goes to DONE, so strobe width = WAIT_STATES[idx] + 1 cycles.
REQ-026 An unmapped idx (DEV_MASK[idx] == 0) asserts no strobe, still spends the same STROBE duration, and raises io_err in DONE.
REQ-027 DONE lasts one cycle: strobes 0, io_done = 1; the FSM then goes to IDLE.
REQ-028 io_wait = start condition (combinational) OR state == STROBE; io_wait = 0 in DONE.
REQ-029 dev_addr, idx and dir hold stable from the start cycle through DONE.
REQ-030 io clears on the first rising edge with state_fetch = 1 while in IDLE or DONE; state_fetch during STROBE is ignored.
REQ-031 Only one transaction runs per exec phase: start is blocked while io = 1, even if io_req and state_exec stay high.
REQ-032 A start request in the DONE cycle is not accepted; it is evaluated again in IDLE.
REQ-033 WAIT_STATES[idx] = 0 gives a one-cycle strobe.
REQ-034 dbus and nwrm changes after start have no effect until the next start.

Reset
REQ-035 nrst = 0 asynchronously forces: state IDLE; io = 0; nio = 1; dev_wr = 0; dev_rd = 0; dev_addr = 0; cnt = 0; io_done = 0; io_err = 0.
REQ-036 Reset mid-STROBE drops every strobe immediately, with no io_done pulse.
REQ-037 After release, the first start is accepted on the first clock edge that meets REQ-022.

Verification
REQ-038 Write, device 2 with wait 1: dbus = 12'h805, nwrm = 0, exec + io_req -> dev_wr = 4'b0100 for 2 cycles, dev_addr = 10'h005, io_wait high for 3 cycles, then io_done for 1 cycle.
REQ-039 Read, device 0 with WAIT_STATES[0] = 0: dbus = 12'h012, nwrm = 1 -> dev_rd = 4'b0001 for 1 cycle, io_rd = 1 while exec, io_done the next cycle.
REQ-040 DEV_MASK = 4'b0111, access to dbus = 12'hC00 -> no strobe, io_err = io_done = 1 after 2 stall cycles.
REQ-041 io_req and state_exec held high for 10 cycles -> exactly one transaction; state_fetch pulse -> io = 0, nio = 1; next exec starts a new transaction.
REQ-042 nrst low during cycle 2 of a 4-cycle strobe -> strobes, io and io_wait drop 0 asynchronously; no io_done.
REQ-043 state_fetch asserted during STROBE -> io stays 1 until the first fetch edge in DONE or IDLE.

Source files
------------

// File: rtl/io_decoder_n.sv
// I/O address decoder with per-device wait states.
// Decodes the top SEL_BITS of dbus into one of N_DEV device strobes and holds
// the strobe for WAIT_STATES[idx]+1 cycles. It then pulses io_done for one
// cycle, with io_err alongside it if the device is unmapped.
// Ports:
//   clk, nrst          clock and asynchronous active-low reset
//   dbus, nwrm         address bus and active-low write
//   state_fetch/exec   CPU phase indicators
//   io_req             current instruction is an I/O access
//   io, nio            registered I/O-phase flag and its complement
//   io_rd              io & state_exec (combinational)
//   dev_wr, dev_rd     registered one-hot device strobes
//   dev_addr           latched low address bits
//   io_wait            CPU stall request (combinational)
//   io_done, io_err    one-cycle completion / unmapped-access pulses
module io_decoder_n #(
   parameter int unsigned ADDR_W   = 12,
   parameter int unsigned SEL_BITS = 2,
   parameter int unsigned WAIT_W   = 3,
   localparam int unsigned N_DEV   = 2**SEL_BITS,
   parameter logic [N_DEV*WAIT_W-1:0] WAIT_STATES = {N_DEV{WAIT_W'(1)}},
   parameter logic [N_DEV-1:0]        DEV_MASK    = '1
) (
   input  logic                       clk,
   input  logic                       nrst,
   input  logic [ADDR_W-1:0]          dbus,
   input  logic                       nwrm,
   input  logic                       state_fetch,
   input  logic                       state_exec,
   input  logic                       io_req,
   output logic                       io,
   output logic                       nio,
   output logic                       io_rd,
   output logic [N_DEV-1:0]           dev_wr,
   output logic [N_DEV-1:0]           dev_rd,
   output logic [ADDR_W-SEL_BITS-1:0] dev_addr,
   output logic                       io_wait,
   output logic                       io_done,
   output logic                       io_err
);

   localparam int unsigned LOW_W = ADDR_W - SEL_BITS;

   typedef enum logic [1:0] {IDLE, STROBE, DONE} state_t;

   state_t              state, state_nxt;
   logic [WAIT_W-1:0]   cnt, cnt_nxt;
   logic [SEL_BITS-1:0] idx, idx_nxt;
   logic                dir, dir_nxt;
   logic [LOW_W-1:0]    addr_nxt;
   logic                io_nxt;
   logic [N_DEV-1:0]    wr_nxt, rd_nxt;
   logic                done_nxt, err_nxt;
   logic                start;
   logic [SEL_BITS-1:0] dbus_idx;
   logic [WAIT_W-1:0]   wait_sel;

   assign dbus_idx = dbus[ADDR_W-1 -: SEL_BITS];

   // Gated by nrst so the stall request also drops while reset is held.
   assign start   = nrst && (state == IDLE) && state_exec && io_req && !io;
   assign io_wait = start || (state == STROBE);
   assign io_rd   = io && state_exec;

   // Wait-state count for the device currently addressed on dbus.
   always_comb begin
      wait_sel = '0;
      for (int k = 0; k < int'(N_DEV); k++) begin
         if (dbus_idx == SEL_BITS'(k)) wait_sel = WAIT_STATES[k*WAIT_W +: WAIT_W];
      end
   end

   // State register and all registered outputs.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state    <= IDLE;
         cnt      <= '0;
         idx      <= '0;
         dir      <= 1'b0;
         dev_addr <= '0;
         io       <= 1'b0;
         nio      <= 1'b1;
         dev_wr   <= '0;
         dev_rd   <= '0;
         io_done  <= 1'b0;
         io_err   <= 1'b0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         idx      <= idx_nxt;
         dir      <= dir_nxt;
         dev_addr <= addr_nxt;
         io       <= io_nxt;
         nio      <= !io_nxt;
         dev_wr   <= wr_nxt;
         dev_rd   <= rd_nxt;
         io_done  <= done_nxt;
         io_err   <= err_nxt;
      end
   end

   // Next-state logic; strobes are derived from the next state so they are
   // high exactly for the cycles the FSM spends in STROBE.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      idx_nxt   = idx;
      dir_nxt   = dir;
      addr_nxt  = dev_addr;
      io_nxt    = io;
      wr_nxt    = '0;
      rd_nxt    = '0;
      done_nxt  = 1'b0;
      err_nxt   = 1'b0;

      case (state)
         IDLE: begin
            if (start) begin
               idx_nxt   = dbus_idx;
               dir_nxt   = !nwrm;
               addr_nxt  = dbus[LOW_W-1:0];
               cnt_nxt   = wait_sel;
               io_nxt    = 1'b1;
               state_nxt = STROBE;
            end else if (state_fetch) begin
               io_nxt = 1'b0;
            end
         end
         STROBE: begin
            if (cnt == '0) begin
               state_nxt = DONE;
               done_nxt  = 1'b1;
               err_nxt   = !DEV_MASK[idx];
            end else begin
               cnt_nxt = cnt - WAIT_W'(1);
            end
         end
         DONE: begin
            state_nxt = IDLE;
            if (state_fetch) io_nxt = 1'b0;
         end
         default: state_nxt = IDLE;
      endcase

      if (state_nxt == STROBE && DEV_MASK[idx_nxt]) begin
         if (dir_nxt) wr_nxt = N_DEV'(1) << idx_nxt;
         else         rd_nxt = N_DEV'(1) << idx_nxt;
      end
   end

endmodule

// File: tb/tb_io_decoder_n.sv
// Self-checking bench for io_decoder_n: per-cycle vector table plus a
// hand-written reset-during-strobe sequence.
module tb_io_decoder_n;

   logic        clk = 1'b0;
   logic        nrst;
   logic [11:0] dbus;
   logic        nwrm, state_fetch, state_exec, io_req;
   logic        io, nio, io_rd, io_wait, io_done, io_err;
   logic [3:0]  dev_wr, dev_rd;
   logic [9:0]  dev_addr;

   int errors = 0;
   int checks = 0;

   // Device waits: dev3=1, dev2=1, dev1=3, dev0=0; device 3 unmapped.
   io_decoder_n #(
      .ADDR_W(12), .SEL_BITS(2), .WAIT_W(3),
      .WAIT_STATES(12'b001_001_011_000),
      .DEV_MASK(4'b0111)
   ) dut (
      .clk(clk), .nrst(nrst), .dbus(dbus), .nwrm(nwrm),
      .state_fetch(state_fetch), .state_exec(state_exec), .io_req(io_req),
      .io(io), .nio(nio), .io_rd(io_rd), .dev_wr(dev_wr), .dev_rd(dev_rd),
      .dev_addr(dev_addr), .io_wait(io_wait), .io_done(io_done), .io_err(io_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [11:0] dbus;
      logic        nwrm, fetch, exec, req;
      logic        io, iowait, iord;
      logic [3:0]  wr, rd;
      logic [9:0]  addr;
      logic        done, err;
   } vec_t;

   vec_t vq[$];

   function automatic vec_t mk(logic [11:0] d, logic nw, logic f, logic e, logic r,
                               logic eio, logic ew, logic erd, logic [3:0] ewr,
                               logic [3:0] erdd, logic [9:0] ea, logic ed, logic ee);
      vec_t v;
      v.dbus = d; v.nwrm = nw; v.fetch = f; v.exec = e; v.req = r;
      v.io = eio; v.iowait = ew; v.iord = erd; v.wr = ewr; v.rd = erdd;
      v.addr = ea; v.done = ed; v.err = ee;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] outs();
      return 32'({io, nio, io_wait, io_rd, dev_wr, dev_rd, dev_addr, io_done, io_err});
   endfunction

   initial begin
      // --- write dev2 (wait 1), inputs changed mid-strobe ---
      vq.push_back(mk(12'h805,0,0,1,1, 0,1,0,4'h0,4'h0,10'h000,0,0));
      vq.push_back(mk(12'h805,0,0,1,1, 1,1,1,4'h4,4'h0,10'h005,0,0));
      vq.push_back(mk(12'h3FF,1,0,1,1, 1,1,1,4'h4,4'h0,10'h005,0,0));
      vq.push_back(mk(12'h3FF,1,0,1,1, 1,0,1,4'h0,4'h0,10'h005,1,0));
      vq.push_back(mk(12'h3FF,1,0,1,1, 1,0,1,4'h0,4'h0,10'h005,0,0));
      vq.push_back(mk(12'h3FF,1,1,0,0, 1,0,0,4'h0,4'h0,10'h005,0,0));
      vq.push_back(mk(12'h3FF,1,0,0,0, 0,0,0,4'h0,4'h0,10'h005,0,0));
      // --- read dev0 (wait 0) ---
      vq.push_back(mk(12'h012,1,0,1,1, 0,1,0,4'h0,4'h0,10'h005,0,0));
      vq.push_back(mk(12'h012,1,0,1,0, 1,1,1,4'h0,4'h1,10'h012,0,0));
      vq.push_back(mk(12'h012,1,0,0,0, 1,0,0,4'h0,4'h0,10'h012,1,0));
      vq.push_back(mk(12'h012,1,1,0,0, 1,0,0,4'h0,4'h0,10'h012,0,0));
      vq.push_back(mk(12'h012,1,0,0,0, 0,0,0,4'h0,4'h0,10'h012,0,0));
      // --- unmapped dev3 (wait 1) ---
      vq.push_back(mk(12'hC00,0,0,1,1, 0,1,0,4'h0,4'h0,10'h012,0,0));
      vq.push_back(mk(12'hC00,0,0,1,1, 1,1,1,4'h0,4'h0,10'h000,0,0));
      vq.push_back(mk(12'hC00,0,0,1,1, 1,1,1,4'h0,4'h0,10'h000,0,0));
      vq.push_back(mk(12'hC00,0,0,0,0, 1,0,0,4'h0,4'h0,10'h000,1,1));
      vq.push_back(mk(12'hC00,0,1,0,0, 1,0,0,4'h0,4'h0,10'h000,0,0));
      vq.push_back(mk(12'hC00,0,0,0,0, 0,0,0,4'h0,4'h0,10'h000,0,0));
      // --- write dev1 (wait 3), fetch during strobe ignored ---
      vq.push_back(mk(12'h4AB,0,0,1,1, 0,1,0,4'h0,4'h0,10'h000,0,0));
      vq.push_back(mk(12'h4AB,0,1,0,0, 1,1,0,4'h2,4'h0,10'h0AB,0,0));
      vq.push_back(mk(12'h4AB,0,1,0,0, 1,1,0,4'h2,4'h0,10'h0AB,0,0));
      vq.push_back(mk(12'h4AB,0,0,0,0, 1,1,0,4'h2,4'h0,10'h0AB,0,0));
      vq.push_back(mk(12'h4AB,0,0,0,0, 1,1,0,4'h2,4'h0,10'h0AB,0,0));
      vq.push_back(mk(12'h4AB,0,1,0,0, 1,0,0,4'h0,4'h0,10'h0AB,1,0));
      vq.push_back(mk(12'h4AB,0,0,0,0, 0,0,0,4'h0,4'h0,10'h0AB,0,0));
      // --- exec/io_req held 10 cycles: one transaction only ---
      vq.push_back(mk(12'h805,0,0,1,1, 0,1,0,4'h0,4'h0,10'h0AB,0,0));
      vq.push_back(mk(12'h805,0,0,1,1, 1,1,1,4'h4,4'h0,10'h005,0,0));
      vq.push_back(mk(12'h805,0,0,1,1, 1,1,1,4'h4,4'h0,10'h005,0,0));
      vq.push_back(mk(12'h805,0,0,1,1, 1,0,1,4'h0,4'h0,10'h005,1,0));
      for (int i = 0; i < 6; i++)
         vq.push_back(mk(12'h805,0,0,1,1, 1,0,1,4'h0,4'h0,10'h005,0,0));
      vq.push_back(mk(12'h805,0,1,0,0, 1,0,0,4'h0,4'h0,10'h005,0,0));
      vq.push_back(mk(12'h805,0,0,1,1, 0,1,0,4'h0,4'h0,10'h005,0,0));
      vq.push_back(mk(12'h805,0,0,0,0, 1,1,0,4'h4,4'h0,10'h005,0,0));
      vq.push_back(mk(12'h805,0,0,0,0, 1,1,0,4'h4,4'h0,10'h005,0,0));
      vq.push_back(mk(12'h805,0,0,0,0, 1,0,0,4'h0,4'h0,10'h005,1,0));
      vq.push_back(mk(12'h805,0,1,0,0, 1,0,0,4'h0,4'h0,10'h005,0,0));
      vq.push_back(mk(12'h805,0,0,0,0, 0,0,0,4'h0,4'h0,10'h005,0,0));

      // Reset with a would-be start request present.
      nrst = 1'b0; dbus = 12'h805; nwrm = 1'b0;
      state_fetch = 1'b0; state_exec = 1'b1; io_req = 1'b1;
      @(negedge clk); #1;
      chk("reset_state", outs(), 32'({1'b0,1'b1,1'b0,1'b0,4'h0,4'h0,10'h000,1'b0,1'b0}));
      state_exec = 1'b0; io_req = 1'b0;
      nrst = 1'b1;

      foreach (vq[i]) begin
         @(negedge clk);
         dbus = vq[i].dbus; nwrm = vq[i].nwrm; state_fetch = vq[i].fetch;
         state_exec = vq[i].exec; io_req = vq[i].req;
         #1;
         chk($sformatf("vec%0d", i), outs(),
             32'({vq[i].io, ~vq[i].io, vq[i].iowait, vq[i].iord, vq[i].wr, vq[i].rd,
                  vq[i].addr, vq[i].done, vq[i].err}));
      end

      // Reset in cycle 2 of a 4-cycle read strobe on dev1.
      @(negedge clk);
      dbus = 12'h4AB; nwrm = 1'b1; state_fetch = 1'b0; state_exec = 1'b1; io_req = 1'b1;
      @(negedge clk); #1;
      chk("rst_pre_rd", 32'(dev_rd), 32'h2);
      @(negedge clk);
      nrst = 1'b0; #1;
      chk("rst_async", 32'({io, nio, io_wait, dev_wr, dev_rd, io_done}), 32'({1'b0,1'b1,1'b0,4'h0,4'h0,1'b0}));
      chk("rst_addr", 32'(dev_addr), 32'h0);
      @(posedge clk); #1;
      chk("rst_no_done", 32'({io_done, io_err, dev_rd}), 32'h0);
      @(negedge clk);
      nrst = 1'b1; #1;
      chk("rel_wait", 32'({io, io_wait}), 32'b01);
      @(negedge clk); #1;
      chk("rel_start", 32'({io, dev_rd, dev_addr}), 32'({1'b1, 4'h2, 10'h0AB}));
      for (int c = 0; c < 3; c++) begin
         @(negedge clk); #1;
         chk($sformatf("rel_rd%0d", c + 2), 32'({dev_rd, io_done}), 32'({4'h2, 1'b0}));
      end
      @(negedge clk); #1;
      chk("rel_done", 32'({dev_rd, io_wait, io_done, io_err}), 32'({4'h0, 1'b0, 1'b1, 1'b0}));
      state_exec = 1'b0; io_req = 1'b0; state_fetch = 1'b1;
      @(negedge clk);
      state_fetch = 1'b0; #1;
      chk("rel_fetch", 32'({io, nio}), 32'b01);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
